// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated rising-edge counter for the divided ring-oscillator clock, result on valid/ready.
// Define RO_FREQ_COUNTER_AUTO_RESTART_EN for back-to-back gating (auto_restart) with a sticky overrun flag.
module ro_freq_counter #(
    parameter int GATE_CYCLES = 4096,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic               div_clk_in,
`ifdef RO_FREQ_COUNTER_AUTO_RESTART_EN
    input  logic               auto_restart,
    output logic               overrun,
`endif
    output logic               busy,
    output logic [COUNT_W-1:0] count_out,
    output logic               count_valid,
    input  logic               count_ready,
    output logic               overflow
);
    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] sync;
    logic                 hist, edge_p, full, sat, sat_next, gate_end, hs, restart;
    logic [TW-1:0]        timer;
    logic [COUNT_W-1:0]   count, count_next;

`ifdef RO_FREQ_COUNTER_AUTO_RESTART_EN
    assign restart = auto_restart;
    // a publish over an unconsumed result flags the loss; the next accepted handshake clears it
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) overrun <= 1'b0;
        else     overrun <= hs ? 1'b0 : overrun | (gate_end & count_valid);
    end
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], div_clk_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        edge_p     = sync[SYNC_STAGES-1] & ~hist;
        full       = &count;
        count_next = (edge_p && !full) ? count + 1'b1 : count;
        sat_next   = sat | (edge_p & full);
        gate_end   = (state == MEASURE) && (timer == LAST);
        hs         = count_valid & count_ready;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            count       <= '0;
            sat         <= 1'b0;
            busy        <= 1'b0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    timer <= '0;
                    count <= '0;
                    sat   <= 1'b0;
                    busy  <= 1'b1;
                    state <= MEASURE;
                end
                MEASURE: begin
                    timer <= timer + 1'b1;
                    count <= count_next;
                    sat   <= sat_next;
                    // the final-cycle edge is folded in; edges still in the synchroniser are dropped
                    if (gate_end) begin
                        count_out   <= count_next;
                        overflow    <= sat_next;
                        count_valid <= 1'b1;
                        timer       <= '0;
                        count       <= '0;
                        sat         <= 1'b0;
                        if (!restart) state <= HOLD;
                    end else if (hs) begin
                        count_valid <= 1'b0;
                    end
                end
                HOLD: if (hs) begin
                    count_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
